wbs_multiport_ram: RTL and testbench

Parametrised multi-port Wishbone slave memory for the CPU testbench top, replacing the fixed two-port instruction/data RAM. It exposes NPORTS identical 32-bit read/write slave ports onto one shared word array. Each port has a programmable wait-state count, range checking with error response, and abort-on-cycle-drop. The CPU instruction and data buses attach as ports 0 and 1; extra ports serve DMA/bench masters.

---
 rtl/wbs_multiport_ram.sv | 132 +++++++++++++
 tb/tb_wbs_multiport_ram.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/wbs_multiport_ram.sv
// Multi-port Wishbone slave RAM: NPORTS independent 32-bit ports onto one shared word array.
// Latency: ack/err in cycle T+1+LATENCY after a request is sampled at edge T; one transfer per 2+LATENCY cycles.
// Backpressure: none across ports; a port stalls only its own master for LATENCY wait states; cyc drop in WAIT aborts.
module wbs_multiport_ram #(
    parameter int          NPORTS     = 2,
    parameter int          ADDR_WIDTH = 24,
    parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
    parameter int          LATENCY    = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [32*NPORTS-1:0]  wbs_addr_i,
    input  logic [32*NPORTS-1:0]  wbs_dat_i,
    input  logic [4*NPORTS-1:0]   wbs_sel_i,
    input  logic [NPORTS-1:0]     wbs_cyc_i,
    input  logic [NPORTS-1:0]     wbs_stb_i,
    input  logic [NPORTS-1:0]     wbs_we_i,
    output logic [32*NPORTS-1:0]  wbs_dat_o,
    output logic [NPORTS-1:0]     wbs_ack_o,
    output logic [NPORTS-1:0]     wbs_err_o
);
    localparam int          IDX_W  = ADDR_WIDTH - 2;
    localparam int          WORDS  = 1 << IDX_W;
    localparam logic [32:0] LIMIT  = {1'b0, BASE_ADDR} + (33'd1 << ADDR_WIDTH);
    localparam logic [3:0]  LAT_M1 = 4'(LATENCY - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

    logic [31:0]       mem [WORDS];
    logic [NPORTS-1:0] wr_en;
    logic [IDX_W-1:0]  wr_idx [NPORTS];
    logic [31:0]       wr_dat [NPORTS];
    logic [3:0]        wr_sel [NPORTS];

    for (genvar p = 0; p < NPORTS; p++) begin : g_port
        state_t           state;
        logic [3:0]       cnt;
        logic             in_range_q;
        logic             we_q;
        logic             ack_q;
        logic             err_q;
        logic [IDX_W-1:0] idx_q;
        logic [3:0]       sel_q;
        logic [31:0]      dat_q;
        logic [31:0]      addr;
        logic             req;
        logic             in_range;

        assign addr     = wbs_addr_i[32*p +: 32];
        assign req      = wbs_cyc_i[p] & wbs_stb_i[p];
        // 33-bit compare so a window ending at 2^32 does not wrap
        assign in_range = ({1'b0, addr} >= {1'b0, BASE_ADDR}) && ({1'b0, addr} < LIMIT);

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                state      <= ST_IDLE;
                cnt        <= '0;
                in_range_q <= 1'b0;
                we_q       <= 1'b0;
                ack_q      <= 1'b0;
                err_q      <= 1'b0;
                idx_q      <= '0;
                sel_q      <= '0;
                dat_q      <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (req) begin
                            in_range_q <= in_range;
                            idx_q      <= addr[ADDR_WIDTH-1:2];
                            we_q       <= wbs_we_i[p];
                            sel_q      <= wbs_sel_i[4*p +: 4];
                            dat_q      <= wbs_dat_i[32*p +: 32];
                            if (LATENCY == 0) begin
                                state <= ST_RESP;
                                ack_q <= in_range;
                                err_q <= ~in_range;
                            end else begin
                                state <= ST_WAIT;
                                cnt   <= LAT_M1;
                            end
                        end
                    end
                    ST_WAIT: begin
                        if (!wbs_cyc_i[p]) begin
                            state <= ST_IDLE;
                            cnt   <= '0;
                        end else if (cnt == 4'd0) begin
                            state <= ST_RESP;
                            ack_q <= in_range_q;
                            err_q <= ~in_range_q;
                        end else begin
                            cnt <= cnt - 4'd1;
                        end
                    end
                    ST_RESP: begin
                        state <= ST_IDLE;
                        ack_q <= 1'b0;
                        err_q <= 1'b0;
                    end
                    default: begin
                        state <= ST_IDLE;
                        ack_q <= 1'b0;
                        err_q <= 1'b0;
                    end
                endcase
            end
        end

        assign wbs_ack_o[p]          = ack_q;
        assign wbs_err_o[p]          = err_q;
        assign wbs_dat_o[32*p +: 32] = (ack_q && !we_q) ? mem[idx_q] : 32'd0;

        assign wr_en[p]  = ack_q & we_q;
        assign wr_idx[p] = idx_q;
        assign wr_dat[p] = dat_q;
        assign wr_sel[p] = sel_q;
    end

    // Ascending port order: the highest-index port's byte wins on a same-cycle collision
    always_ff @(posedge clk_i) begin
        for (int p = 0; p < NPORTS; p++) begin
            if (wr_en[p]) begin
                for (int b = 0; b < 4; b++) begin
                    if (wr_sel[p][b]) begin
                        mem[wr_idx[p]][8*b +: 8] <= wr_dat[p][8*b +: 8];
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_wbs_multiport_ram.sv
// Directed bench for wbs_multiport_ram: four 2-port instances at LATENCY 0, 3, 5 and 4.
module tb_wbs_multiport_ram;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [63:0] addr [4];
    logic [63:0] wdat [4];
    logic [63:0] rdat [4];
    logic [7:0]  sel  [4];
    logic [1:0]  cyc  [4];
    logic [1:0]  stb  [4];
    logic [1:0]  we   [4];
    logic [1:0]  ack  [4];
    logic [1:0]  err  [4];

    int passes = 0;
    int fails  = 0;
    int total  = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        wbs_multiport_ram #(
            .NPORTS     (2),
            .ADDR_WIDTH (24),
            .BASE_ADDR  (32'h8000_0000),
            .LATENCY    (g == 0 ? 0 : g == 1 ? 3 : g == 2 ? 5 : 4)
        ) u_ram (
            .clk_i      (clk),
            .rst_ni     (rst_n),
            .wbs_addr_i (addr[g]),
            .wbs_dat_i  (wdat[g]),
            .wbs_sel_i  (sel[g]),
            .wbs_cyc_i  (cyc[g]),
            .wbs_stb_i  (stb[g]),
            .wbs_we_i   (we[g]),
            .wbs_dat_o  (rdat[g]),
            .wbs_ack_o  (ack[g]),
            .wbs_err_o  (err[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int i, input int p, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s);
        cyc[i][p]          = 1'b1;
        stb[i][p]          = 1'b1;
        we[i][p]           = w;
        addr[i][32*p +: 32] = a;
        wdat[i][32*p +: 32] = d;
        sel[i][4*p +: 4]    = s;
    endtask

    task automatic release_port(input int i, input int p);
        cyc[i][p] = 1'b0;
        stb[i][p] = 1'b0;
        we[i][p]  = 1'b0;
    endtask

    // One complete transfer; checks latency (edges until response), response kind, data and pulse width
    task automatic xfer(input int i, input int p, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] s, input logic exp_err,
                        input logic [31:0] exp_dat, input int exp_lat, input string tag);
        int n = 0;
        drive(i, p, w, a, d, s);
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!(ack[i][p] | err[i][p]) && n < 40);
        check({tag, " lat"}, 32'(n), 32'(exp_lat));
        check({tag, " ack"}, {31'd0, ack[i][p]}, {31'd0, ~exp_err});
        check({tag, " err"}, {31'd0, err[i][p]}, {31'd0, exp_err});
        check({tag, " dat"}, rdat[i][32*p +: 32], exp_dat);
        release_port(i, p);
        @(posedge clk);
        #1;
        check({tag, " pulse"}, {30'd0, ack[i][p], err[i][p]}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its summary");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;
        for (int i = 0; i < 4; i++) begin
            addr[i] = '0; wdat[i] = '0; sel[i] = '0;
            cyc[i] = '0; stb[i] = '0; we[i] = '0;
        end
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rst ack%0d", i), {30'd0, ack[i]}, 32'd0);
            check($sformatf("rst err%0d", i), {30'd0, err[i]}, 32'd0);
            check($sformatf("rst dat%0d", i), rdat[i][31:0] | rdat[i][63:32], 32'd0);
        end
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // LATENCY 0 write on port 1, read back on port 0
        xfer(0, 1, 1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 1'b0, 32'h0, 1, "l0_wr");
        xfer(0, 0, 1'b0, 32'h8000_0010, 32'h0, 4'hF, 1'b0, 32'hDEAD_BEEF, 1, "l0_rd");

        // LATENCY 3 byte lanes
        xfer(1, 0, 1'b1, 32'h8000_0000, 32'h1122_3344, 4'hF, 1'b0, 32'h0, 4, "l3_pre");
        xfer(1, 1, 1'b1, 32'h8000_0000, 32'h0000_00AA, 4'h1, 1'b0, 32'h0, 4, "l3_lane");
        xfer(1, 0, 1'b0, 32'h8000_0000, 32'h0, 4'hF, 1'b0, 32'h1122_33AA, 4, "l3_rd");

        // Range checking; 8100_0000 would alias word 0 if the check were missing
        xfer(0, 0, 1'b1, 32'h8000_0000, 32'hCAFE_F00D, 4'hF, 1'b0, 32'h0, 1, "oor_pre");
        xfer(0, 0, 1'b0, 32'h7FFF_FFFC, 32'h0, 4'hF, 1'b1, 32'h0, 1, "oor_rd");
        xfer(0, 1, 1'b1, 32'h8100_0000, 32'hFFFF_FFFF, 4'hF, 1'b1, 32'h0, 1, "oor_wr");
        xfer(0, 0, 1'b0, 32'h8000_0000, 32'h0, 4'hF, 1'b0, 32'hCAFE_F00D, 1, "oor_chk");
        xfer(0, 1, 1'b1, 32'h80FF_FFFC, 32'h1357_9BDF, 4'hF, 1'b0, 32'h0, 1, "top_wr");
        xfer(0, 0, 1'b0, 32'h80FF_FFFF, 32'h0, 4'hF, 1'b0, 32'h1357_9BDF, 1, "top_rd");

        // Same-cycle collision: port 1 owns bytes 1:0, port 0 keeps bytes 3:2
        drive(0, 0, 1'b1, 32'h8000_0040, 32'hAAAA_AAAA, 4'hF);
        drive(0, 1, 1'b1, 32'h8000_0040, 32'h0000_BBBB, 4'h3);
        @(posedge clk);
        #1;
        check("col ack", {30'd0, ack[0]}, 32'd3);
        release_port(0, 0);
        release_port(0, 1);
        @(posedge clk);
        #1;
        xfer(0, 1, 1'b0, 32'h8000_0040, 32'h0, 4'hF, 1'b0, 32'hAAAA_BBBB, 1, "col_rd");

        // Abort: cyc dropped in the second WAIT cycle at LATENCY 5
        xfer(2, 0, 1'b1, 32'h8000_0020, 32'h0BAD_F00D, 4'hF, 1'b0, 32'h0, 6, "ab_pre");
        drive(2, 0, 1'b1, 32'h8000_0020, 32'h1234_5678, 4'hF);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        release_port(2, 0);
        seen = 1'b0;
        repeat (10) begin
            @(posedge clk);
            #1;
            seen = seen | ack[2][0] | err[2][0];
        end
        check("ab quiet", {31'd0, seen}, 32'd0);
        xfer(2, 0, 1'b0, 32'h8000_0020, 32'h0, 4'hF, 1'b0, 32'h0BAD_F00D, 6, "ab_rd");

        // Reset during WAIT at LATENCY 4
        xfer(3, 0, 1'b1, 32'h8000_0030, 32'h600D_CAFE, 4'hF, 1'b0, 32'h0, 5, "rs_pre");
        drive(3, 0, 1'b1, 32'h8000_0030, 32'h5555_5555, 4'hF);
        @(posedge clk);
        #1;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rs async", {30'd0, ack[3][0], err[3][0]}, 32'd0);
        release_port(3, 0);
        #2 rst_n = 1'b1;
        seen = 1'b0;
        repeat (8) begin
            @(posedge clk);
            #1;
            seen = seen | ack[3][0] | err[3][0];
        end
        check("rs quiet", {31'd0, seen}, 32'd0);
        xfer(3, 0, 1'b0, 32'h8000_0030, 32'h0, 4'hF, 1'b0, 32'h600D_CAFE, 5, "rs_rd");
        xfer(3, 1, 1'b1, 32'h8000_0030, 32'h5555_5555, 4'hF, 1'b0, 32'h0, 5, "rs_wr");
        xfer(3, 0, 1'b0, 32'h8000_0030, 32'h0, 4'hF, 1'b0, 32'h5555_5555, 5, "rs_rd2");

        // Reset asserted mid-cycle while ack is high clears outputs before any edge
        drive(0, 0, 1'b0, 32'h8000_0010, 32'h0, 4'hF);
        @(posedge clk);
        #1;
        check("ra ack", {31'd0, ack[0][0]}, 32'd1);
        check("ra dat", rdat[0][31:0], 32'hDEAD_BEEF);
        #2 rst_n = 1'b0;
        #1;
        check("ra ack0", {31'd0, ack[0][0]}, 32'd0);
        check("ra dat0", rdat[0][31:0], 32'd0);
        release_port(0, 0);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("ra idle", {30'd0, ack[0]}, 32'd0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
